twos_comp_serial_ctrl: RTL and testbench

// Scheduler/sequencer for the bit-serial two's-complement engine (Mealy FSM: copy bits
// up to and including the first 1, invert thereafter, LSB first). Accepts parallel words

---
 rtl/tcs_pkg.sv | 18 +
 rtl/twos_comp_serial_ctrl_if.sv | 34 +++
 rtl/twos_comp_serial_ctrl_rr_arbiter.sv | 46 ++++
 rtl/twos_comp_serial_ctrl.sv | 114 +++++++++++
 tb/tb_twos_comp_serial_ctrl.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcs_pkg.sv
// Shared state encodings and sizing helper for the
// two's-complement serial controller.
package tcs_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLR   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/twos_comp_serial_ctrl_if.sv
// Request, result and serial-engine signals of the
// two's-complement serial controller.
interface twos_comp_serial_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int IDW   = 1
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  eng_clr;
    logic                  eng_en;
    logic                  eng_in;
    logic                  eng_out;
    logic                  res_valid;
    logic [WIDTH-1:0]      res_data;
    logic [IDW-1:0]        res_id;
    logic                  res_ready;
    logic                  busy;

    modport master (
        output req_valid, req_data, res_ready, eng_out,
        input  req_ready, eng_clr, eng_en, eng_in,
        input  res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_data, res_ready, eng_out,
        output req_ready, eng_clr, eng_en, eng_in,
        output res_valid, res_data, res_id, busy
    );

endinterface

// File: rtl/twos_comp_serial_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and encoded index,
// searching from the requester after the last grant.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    logic [IDW-1:0] last;
    logic [IDW-1:0] kk;
    int             k;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        k       = 0;
        kk      = '0;
        for (int off = 1; off <= NREQ; off++) begin
            k = int'(last) + off;
            if (k >= NREQ) k = k - NREQ;
            kk = IDW'(k);
            if (!any && req[kk]) begin
                any     = 1'b1;
                gnt[kk] = 1'b1;
                gnt_idx = kk;
            end
        end
    end

    // Pointer starts at the last index so requester 0 wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last <= IDW'(NREQ - 1);
        else if (advance && any)
            last <= gnt_idx;
    end

endmodule

// File: rtl/twos_comp_serial_ctrl.sv
// Sequencer that feeds parallel words through the bit-serial
// negation engine and returns (-x) mod 2^WIDTH with the requester id.
module twos_comp_serial_ctrl
    import tcs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int IDW   = clog2(NREQ)
) (
    input logic                clk,
    input logic                reset,
    twos_comp_serial_ctrl_if.slave bus
);

    localparam int CW = clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sel;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   gidx;
    logic [CW-1:0]    cnt;
    logic [NREQ-1:0]  gnt;
    logic             any;
    logic             take;
    logic             last_bit;

    assign take          = (state == ST_IDLE) && any;
    assign bus.req_ready = (state == ST_IDLE) ? gnt : '0;
    assign last_bit      = (cnt == CW'(WIDTH - 1));

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req_valid),
        .advance (take),
        .gnt     (gnt),
        .gnt_idx (gidx),
        .any     (any)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) sel = sel | bus.req_data[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            sreg          <= '0;
            acc           <= '0;
            id_q          <= '0;
            cnt           <= '0;
            bus.eng_clr   <= 1'b0;
            bus.eng_en    <= 1'b0;
            bus.eng_in    <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= '0;
            bus.busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (any) begin
                        sreg        <= sel;
                        id_q        <= gidx;
                        bus.eng_clr <= 1'b1;
                        bus.busy    <= 1'b1;
                        state       <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    bus.eng_clr <= 1'b0;
                    bus.eng_en  <= 1'b1;
                    bus.eng_in  <= sreg[0];
                    sreg        <= sreg >> 1;
                    cnt         <= '0;
                    state       <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Engine output lands in the MSB; LSB-first
                    // bits end up in order after WIDTH shifts.
                    acc <= {bus.eng_out, acc[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        bus.eng_en    <= 1'b0;
                        bus.eng_in    <= 1'b0;
                        bus.res_valid <= 1'b1;
                        bus.res_data  <= {bus.eng_out, acc[WIDTH-1:1]};
                        bus.res_id    <= id_q;
                        state         <= ST_DONE;
                    end else begin
                        bus.eng_in <= sreg[0];
                        sreg       <= sreg >> 1;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twos_comp_serial_ctrl.sv
// Bench for twos_comp_serial_ctrl with a behavioural serial
// negation engine and a round-robin/arithmetic reference model.
module tb_twos_comp_serial_ctrl;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int IW = 1;
    localparam int M  = 1 << W;

    logic clk = 1'b0;
    logic reset;
    logic seen1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tot_en = 0;
    int tot_clr = 0;
    int last_m = N - 1;

    logic [W-1:0] q [N][$];
    int exp_d[$];
    int exp_i[$];
    int log_d[$];
    int log_i[$];

    twos_comp_serial_ctrl_if #(.WIDTH(W), .NREQ(N), .IDW(IW)) bus ();

    twos_comp_serial_ctrl #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && bus.eng_en) tot_en <= tot_en + 1;
        if (!reset && bus.eng_clr) tot_clr <= tot_clr + 1;
    end

    // Serial engine: pass bits through until the first 1, invert after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) seen1 <= 1'b0;
        else if (bus.eng_clr) seen1 <= 1'b0;
        else if (bus.eng_en && bus.eng_in) seen1 <= 1'b1;
    end
    assign bus.eng_out = seen1 ? ~bus.eng_in : bus.eng_in;

    function automatic int neg(input int x);
        return (M - x) % M;
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_m = N - 1;
        exp_d.delete();
        exp_i.delete();
        log_d.delete();
        log_i.delete();
        for (int r = 0; r < N; r++) q[r].delete();
    endtask

    task automatic run_traffic(input int vpct, input int rpct,
                               input int max_cyc);
        logic [N-1:0] popv;
        logic [N-1:0] wantg;
        int n;
        int g;
        int en_base;
        int clr_base;
        bit fin;
        popv = '0;
        n = 0;
        fin = 0;
        en_base = tot_en;
        clr_base = tot_clr;
        while (n < max_cyc && !fin) begin
            @(posedge clk);
            #1;
            for (int r = 0; r < N; r++)
                if (popv[r]) void'(q[r].pop_front());
            popv = '0;
            for (int r = 0; r < N; r++) begin
                bus.req_valid[r] = (q[r].size() > 0) &&
                                   ($urandom_range(99) < vpct);
                bus.req_data[r*W +: W] = (q[r].size() > 0) ? q[r][0] : '0;
            end
            bus.res_ready = ($urandom_range(99) < rpct);
            fin = (exp_d.size() == 0);
            for (int r = 0; r < N; r++)
                if (q[r].size() > 0) fin = 0;
            if (!fin) begin
                @(negedge clk);
                n++;
                if (bus.res_valid && bus.res_ready) begin
                    total++;
                    if (exp_d.size() == 0) begin
                        bad++;
                        $display("FAIL res_unexpected got=%0h want=none",
                                 bus.res_data);
                    end else begin
                        if (int'(bus.res_data) !== exp_d[0] ||
                            int'(bus.res_id) !== exp_i[0] ||
                            tot_en - en_base !== W ||
                            tot_clr - clr_base !== 1) begin
                            bad++;
                            $display("FAIL res_word got=%0h/id%0d/en%0d/clr%0d want=%0h/id%0d/en%0d/clr1",
                                     bus.res_data, bus.res_id,
                                     tot_en - en_base, tot_clr - clr_base,
                                     exp_d[0], exp_i[0], W);
                        end
                        log_d.push_back(int'(bus.res_data));
                        log_i.push_back(int'(bus.res_id));
                        void'(exp_d.pop_front());
                        void'(exp_i.pop_front());
                    end
                end
                if (bus.busy) begin
                    total++;
                    if (bus.req_ready !== '0) begin
                        bad++;
                        $display("FAIL ready_while_busy got=%b want=0",
                                 bus.req_ready);
                    end
                end else begin
                    g = -1;
                    for (int o = 1; o <= N; o++)
                        if (g < 0 && bus.req_valid[(last_m + o) % N])
                            g = (last_m + o) % N;
                    wantg = '0;
                    if (g >= 0) wantg[g] = 1'b1;
                    total++;
                    if (bus.req_ready !== wantg) begin
                        bad++;
                        $display("FAIL rr_grant got=%b want=%b",
                                 bus.req_ready, wantg);
                    end
                    if (g >= 0) begin
                        exp_d.push_back(neg(int'(q[g][0])));
                        exp_i.push_back(g);
                        popv[g] = 1'b1;
                        last_m = g;
                        en_base = tot_en;
                        clr_base = tot_clr;
                    end
                end
            end
        end
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL traffic_timeout got=%0d want<%0d", n, max_cyc);
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.res_ready = 1'b0;
        #12;
        total++;
        if ({bus.req_ready, bus.eng_clr, bus.eng_en, bus.eng_in,
             bus.res_valid, bus.res_data, bus.res_id, bus.busy} !== '0) begin
            bad++;
            $display("FAIL reset_outs got=%b want=0",
                     {bus.req_ready, bus.eng_clr, bus.eng_en, bus.eng_in,
                      bus.res_valid, bus.res_data, bus.res_id, bus.busy});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 2'b01;
        bus.req_data = {8'h00, 8'h05};
        @(negedge clk);
        total++;
        if (bus.req_ready !== 2'b01) begin
            bad++;
            $display("FAIL reset_grant got=%b want=01", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.eng_en !== 1'b1 || bus.eng_in !== 1'b1) begin
            bad++;
            $display("FAIL shift3 got=%b%b want=11", bus.eng_en, bus.eng_in);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({bus.req_ready, bus.eng_clr, bus.eng_en, bus.eng_in,
             bus.res_valid, bus.res_data, bus.res_id, bus.busy} !== '0) begin
            bad++;
            $display("FAIL midshift_reset got=%b want=0",
                     {bus.req_ready, bus.eng_clr, bus.eng_en, bus.eng_in,
                      bus.res_valid, bus.res_data, bus.res_id, bus.busy});
        end
        @(negedge clk);
        reset = 1'b0;
        last_m = N - 1;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.eng_clr !== 1'b0 ||
            bus.eng_en !== 1'b0 || bus.res_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle got=%b%b%b%b want=0000",
                     bus.busy, bus.eng_clr, bus.eng_en, bus.res_valid);
        end
    endtask

    task automatic test_single;
        int gc;
        int en_base;
        int clr_base;
        bit got;
        do_reset();
        @(posedge clk);
        #1;
        bus.req_valid = 2'b01;
        bus.req_data = {8'h00, 8'h05};
        @(negedge clk);
        total++;
        if (bus.req_ready !== 2'b01) begin
            bad++;
            $display("FAIL single_ready got=%b want=01", bus.req_ready);
        end
        gc = cyc;
        en_base = tot_en;
        clr_base = tot_clr;
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 2'b00 || bus.eng_clr !== 1'b1 ||
            bus.eng_en !== 1'b0) begin
            bad++;
            $display("FAIL single_clr got=%b/%b%b want=00/10",
                     bus.req_ready, bus.eng_clr, bus.eng_en);
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.res_valid) got = 1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL single_timeout got=0 want=res_valid");
        end else if (cyc - gc !== W + 2 || bus.res_data !== 8'hFB ||
                     bus.res_id !== 1'b0 || tot_en - en_base !== W ||
                     tot_clr - clr_base !== 1) begin
            bad++;
            $display("FAIL single_res got=lat%0d/%0h/id%0d/en%0d/clr%0d want=lat%0d/fb/id0/en%0d/clr1",
                     cyc - gc, bus.res_data, bus.res_id,
                     tot_en - en_base, tot_clr - clr_base, W + 2, W);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_release got=%b%b want=00",
                     bus.res_valid, bus.busy);
        end
    endtask

    task automatic test_back_to_back;
        int ids[4];
        int dat[4];
        ids = '{0, 1, 0, 1};
        dat = '{'hFF, 'h80, 'hFF, 'h80};
        do_reset();
        q[0].push_back(8'h01);
        q[0].push_back(8'h01);
        q[1].push_back(8'h80);
        q[1].push_back(8'h80);
        run_traffic(100, 100, 400);
        total++;
        if (log_i.size() !== 4) begin
            bad++;
            $display("FAIL rr_count got=%0d want=4", log_i.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (log_i[i] !== ids[i] || log_d[i] !== dat[i]) begin
                    bad++;
                    $display("FAIL rr_order%0d got=id%0d/%0h want=id%0d/%0h",
                             i, log_i[i], log_d[i], ids[i], dat[i]);
                end
            end
        end
    endtask

    task automatic test_edges;
        int dat[4];
        dat = '{'h00, 'hFF, 'h80, 'h01};
        do_reset();
        q[1].push_back(8'h00);
        q[1].push_back(8'h01);
        q[1].push_back(8'h80);
        q[1].push_back(8'hFF);
        run_traffic(100, 100, 400);
        total++;
        if (log_d.size() !== 4) begin
            bad++;
            $display("FAIL edge_count got=%0d want=4", log_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (log_d[i] !== dat[i] || log_i[i] !== 1) begin
                    bad++;
                    $display("FAIL edge%0d got=%0h/id%0d want=%0h/id1",
                             i, log_d[i], log_i[i], dat[i]);
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [W-1:0] hold;
        bit got;
        do_reset();
        @(posedge clk);
        #1;
        bus.req_valid = 2'b01;
        bus.req_data = {8'h00, 8'h33};
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.res_valid) got = 1;
        end
        hold = bus.res_data;
        total++;
        if (!got || hold !== 8'hCD) begin
            bad++;
            $display("FAIL stall_first got=%b/%0h want=1/cd", got, hold);
        end
        bus.req_valid = 2'b10;
        bus.req_data = {8'h10, 8'h00};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== hold ||
                bus.req_ready !== 2'b00 || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold%0d got=%b/%0h/%b/%b want=1/%0h/00/1",
                         i, bus.res_valid, bus.res_data, bus.req_ready,
                         bus.busy, hold);
            end
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 ||
            bus.req_ready !== 2'b10) begin
            bad++;
            $display("FAIL stall_idle got=%b/%b/%b want=0/0/10",
                     bus.busy, bus.res_valid, bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        total++;
        if (bus.busy !== 1'b1 || bus.eng_clr !== 1'b1) begin
            bad++;
            $display("FAIL stall_regrant got=%b%b want=11",
                     bus.busy, bus.eng_clr);
        end
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.res_valid) got = 1;
        end
        total++;
        if (!got || bus.res_data !== 8'hF0 || bus.res_id !== 1'b1) begin
            bad++;
            $display("FAIL stall_second got=%b/%0h/id%0d want=1/f0/id1",
                     got, bus.res_data, bus.res_id);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_random;
        int r;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            r = int'($urandom_range(N - 1));
            q[r].push_back(W'($urandom));
        end
        run_traffic(70, 60, 60000);
        total++;
        if (log_d.size() !== 1000) begin
            bad++;
            $display("FAIL random_count got=%0d want=1000", log_d.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_edges();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
